// File: rtl/bus_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch master and a
// load/store master. Data wins ties unless the fetch side has been starved too long.
module bus_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic        stall_req,
  output logic [1:0]  dbg_state
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  // Handshake: a master holds req and its payload stable until the single-cycle
  // ack; the arbiter samples requests only in IDLE, so payload changes during an
  // access are invisible to it.
  typedef enum logic [1:0] {IDLE = 2'd0, I_ACC = 2'd1, D_ACC = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          own_d_q, own_d_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          err_q, err_d;
  logic          starved;
  logic          acc;

  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    own_d_d  = own_d_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && starved)) begin
          state_d = D_ACC;
          own_d_d = 1'b1;
          we_d    = d_we;
          sel_d   = d_sel;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wait_d  = '0;
          if (i_req) starve_d = starve_q + 1'b1;
        end else if (i_req) begin
          state_d  = I_ACC;
          own_d_d  = 1'b0;
          we_d     = 1'b0;
          sel_d    = 4'b1111;
          addr_d   = i_addr;
          wdata_d  = '0;
          wait_d   = '0;
          starve_d = '0;
        end
      end
      I_ACC, D_ACC: begin
        if (mem_ready) begin
          // A ready arriving on the last allowed wait cycle still completes cleanly.
          state_d = DONE;
          err_d   = 1'b0;
          if (own_d_q) drdata_d = mem_rdata;
          else         irdata_d = mem_rdata;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          wait_d  = wait_q + 1'b1;
          if (own_d_q) drdata_d = '0;
          else         irdata_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      own_d_q  <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      own_d_q  <= own_d_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      err_q    <= err_d;
    end
  end

  assign acc       = (state_q == I_ACC) || (state_q == D_ACC);
  assign mem_ce    = acc;
  assign mem_we    = acc & we_q;
  assign mem_sel   = acc ? sel_q : 4'b0000;
  assign mem_addr  = acc ? addr_q : 32'h0;
  assign mem_wdata = acc ? wdata_q : 32'h0;
  assign i_ack     = (state_q == DONE) & ~own_d_q;
  assign d_ack     = (state_q == DONE) & own_d_q;
  assign bus_err   = (state_q == DONE) & err_q;
  assign i_rdata   = irdata_q;
  assign d_rdata   = drdata_q;
  assign stall_req = (i_req & ~i_ack) | (d_req & ~d_ack);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a transaction-level model predicts every output
// each cycle, and directed scenarios pin latencies, ordering and error behaviour.
module tb_bus_arbiter;

  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_sel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_ce, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, bus_err, stall_req;
  logic [1:0]  dbg_state;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .stall_req(stall_req), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int unsigned rdy_delay  = 0;
  logic [31:0] rd_val     = 32'h0;
  bit          idle_ready = 1'b0;

  initial begin
    int acc_n;
    acc_n     = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ce) begin
        acc_n++;
        mem_ready = (acc_n == int'(rdy_delay) + 1);
      end else begin
        acc_n     = 0;
        mem_ready = idle_ready;
      end
      mem_rdata = rd_val;
    end
  end

  // ---------------- transaction-level model ----------------
  // m_owner: 0 = nobody, 1 = fetch, 2 = data. m_age counts access cycles served.
  int          m_owner = 0;
  int          m_age = 0;
  int          m_starve = 0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_irdata = 32'h0, m_drdata = 32'h0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_owner = 0; m_age = 0; m_starve = 0; m_done = 0; m_err = 0;
        m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
      end else if (m_done) begin
        m_done  = 1'b0;
        m_owner = 0;
      end else if (m_owner != 0) begin
        m_age++;
        if (mem_ready || m_age >= TIMEOUT) begin
          m_done = 1'b1;
          m_err  = !mem_ready;
          if (m_owner == 1) m_irdata = mem_ready ? mem_rdata : 32'h0;
          else              m_drdata = mem_ready ? mem_rdata : 32'h0;
        end
      end else if (d_req && !(i_req && m_starve >= STARVE_MAX)) begin
        m_owner = 2; m_age = 0;
        m_we = d_we; m_sel = d_sel; m_addr = d_addr; m_wdata = d_wdata;
        if (i_req) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      end else if (i_req) begin
        m_owner = 1; m_age = 0; m_starve = 0;
        m_we = 1'b0; m_sel = 4'b1111; m_addr = i_addr; m_wdata = 32'h0;
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    bit acc, ei, ed;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        acc = (m_owner != 0) && !m_done;
        ei  = m_done && (m_owner == 1);
        ed  = m_done && (m_owner == 2);
        chk("mem_ce", mem_ce, acc);
        chk("mem_we", mem_we, acc && m_we);
        chk("mem_sel", mem_sel, acc ? m_sel : 4'h0);
        chk("mem_addr", mem_addr, acc ? m_addr : 32'h0);
        chk("mem_wdata", mem_wdata, acc ? m_wdata : 32'h0);
        chk("i_ack", i_ack, ei);
        chk("d_ack", d_ack, ed);
        chk("bus_err", bus_err, m_done && m_err);
        chk("i_rdata", i_rdata, m_irdata);
        chk("d_rdata", d_rdata, m_drdata);
        chk("stall_req", stall_req, (i_req && !ei) || (d_req && !ed));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_i(input logic [31:0] a, output int n_acc, output int t_req,
                      output int t_ack);
    bit seen;
    seen = 0; n_acc = 0; t_ack = -1;
    i_req = 1'b1; i_addr = a; t_req = int'(cyc);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (mem_ce) n_acc++;
      if (i_ack) begin seen = 1; t_ack = int'(cyc); end
    end
    if (!seen) chk("i_ack_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd, output int n_acc, output logic err,
                      output int t_ack, output logic [4:0] first_we_sel);
    bit seen;
    seen = 0; n_acc = 0; err = 0; t_ack = -1; first_we_sel = 5'h0;
    d_req = 1'b1; d_addr = a; d_we = we; d_sel = sel; d_wdata = wd;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (mem_ce) begin
        if (n_acc == 0) first_we_sel = {mem_we, mem_sel};
        n_acc++;
      end
      if (d_ack) begin seen = 1; err = bus_err; t_ack = int'(cyc); end
    end
    if (!seen) chk("d_ack_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n_a, n_b, t_a, t_b, t_c, n_d;
    logic e_a;
    logic [4:0] ws;
    bit seen;
    rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_sel = 0; d_addr = 0; d_wdata = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_ce", mem_ce, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_state", dbg_state, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // fetch only, minimum latency
    rd_val = 32'hDEADBEEF; rdy_delay = 0;
    do_i(32'h100, n_a, t_a, t_b);
    chk("fetch_latency", t_b - t_a, 32'd2);
    chk("fetch_mem_ce_cycles", n_a, 32'd1);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);

    // simultaneous requests: data first, then fetch three cycles later
    idle_ready = 1'b1; rd_val = 32'h0000_55AA;
    fork
      do_d(32'h200, 1'b1, 4'b0011, 32'h1234, n_b, e_a, t_c, ws);
      do_i(32'h300, n_a, t_a, t_b);
    join
    chk("sim_first_we_sel", ws, 5'b1_0011);
    chk("sim_fetch_after_data", t_b - t_c, 32'd3);
    chk("sim_d_rdata", d_rdata, 32'h0000_55AA);

    // starvation: data held high, fetch waits exactly STARVE_MAX data grants
    rd_val = 32'h0BAD_F00D;
    d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h400; d_wdata = 32'h0;
    i_req = 1; i_addr = 32'h500;
    n_d = 0; seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (d_ack) n_d++;
      if (i_ack) seen = 1;
    end
    chk("starve_seen_i_ack", seen, 32'd1);
    chk("starve_data_grants", n_d, 32'd4);
    @(posedge clk); #1;
    d_req = 0; i_req = 0;
    repeat (3) @(posedge clk);
    #1 idle_ready = 1'b0;

    // timeout: never ready
    rdy_delay = 100; rd_val = 32'h0000_CAFE;
    do_d(32'h600, 1'b0, 4'hF, 32'h0, n_a, e_a, t_a, ws);
    chk("timeout_wait_cycles", n_a, 32'd16);
    chk("timeout_bus_err", e_a, 32'd1);
    chk("timeout_rdata", d_rdata, 32'd0);

    // ready on the last allowed cycle wins
    rdy_delay = 15; rd_val = 32'hBEEF_0001;
    do_d(32'h604, 1'b0, 4'hF, 32'h0, n_a, e_a, t_a, ws);
    chk("late_ready_cycles", n_a, 32'd16);
    chk("late_ready_bus_err", e_a, 32'd0);
    chk("late_ready_rdata", d_rdata, 32'hBEEF_0001);

    // reset in the middle of a data access
    rdy_delay = 100;
    d_req = 1; d_addr = 32'h700; d_we = 1; d_sel = 4'b0101; d_wdata = 32'h99;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_ce) seen = 1;
    end
    chk("rst_test_granted", seen, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; d_req = 0; d_we = 0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_ce", mem_ce, 32'd0);
    chk("abort_d_ack", d_ack, 32'd0);
    chk("abort_state", dbg_state, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rdy_delay = 0; rd_val = 32'h0000_0077;
    do_d(32'h800, 1'b0, 4'hF, 32'h0, n_a, e_a, t_a, ws);
    chk("post_rst_cycles", n_a, 32'd1);
    chk("post_rst_bus_err", e_a, 32'd0);
    chk("post_rst_rdata", d_rdata, 32'h0000_0077);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
